// File: rtl/fb_pkg.sv
// Shared types and screen geometry for the
// framebuffer sprite blitter.
package fb_pkg;

  localparam int FB_W = 320;
  localparam int FB_H = 240;

  typedef logic [16:0] fb_addr_t;
  typedef logic [3:0]  color_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FINISH
  } blit_state_t;

endpackage

// File: rtl/blit_addr_gen.sv
// Row-major pixel walker: col/row counters plus
// incremental ROM address, destination and fb row base.
module blit_addr_gen #(
  parameter int STRIDE = 320
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [16:0]        base,
  input  logic [8:0]         w,
  input  logic [7:0]         h,
  input  logic [9:0]         x0,
  input  logic [8:0]         y0,
  output logic [16:0]        src_addr,
  output logic signed [10:0] dx,
  output logic signed [10:0] dy,
  output logic [16:0]        row_base,
  output logic               last
);
  import fb_pkg::*;

  localparam fb_addr_t STEP = fb_addr_t'(STRIDE);

  logic [8:0]         col;
  logic [8:0]         w_q;
  logic [7:0]         row;
  logic [7:0]         h_q;
  fb_addr_t           line;
  logic signed [10:0] x_q;
  fb_addr_t           y_ext;
  logic               eol;

  assign y_ext = {{8{y0[8]}}, y0};
  assign eol   = (col == w_q - 9'd1);
  assign last  = eol && (row == h_q - 8'd1);

  // Only the low 17 bits of the row base matter:
  // the write address is taken modulo 2^17.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      x_q      <= '0;
      line     <= '0;
      src_addr <= '0;
      dx       <= '0;
      dy       <= '0;
      row_base <= '0;
    end else if (load) begin
      col      <= '0;
      row      <= '0;
      w_q      <= w;
      h_q      <= h;
      x_q      <= {x0[9], x0};
      line     <= base;
      src_addr <= base;
      dx       <= {x0[9], x0};
      dy       <= {{2{y0[8]}}, y0};
      row_base <= fb_addr_t'(y_ext * STEP);
    end else if (step) begin
      if (eol) begin
        col      <= '0;
        row      <= row + 8'd1;
        line     <= line + fb_addr_t'(w_q);
        src_addr <= line + fb_addr_t'(w_q);
        dx       <= x_q;
        dy       <= dy + 11'sd1;
        row_base <= row_base + STEP;
      end else begin
        col      <= col + 9'd1;
        src_addr <= src_addr + 17'd1;
        dx       <= dx + 11'sd1;
      end
    end
  end

endmodule

// File: rtl/fb_sprite_blitter.sv
// Sprite ROM to framebuffer blitter with colour key,
// screen-edge clipping and solid fill.
module fb_sprite_blitter #(
  parameter int FB_W    = fb_pkg::FB_W,
  parameter int FB_H    = fb_pkg::FB_H,
  parameter int SRC_LAT = 1
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        fill_mode,
  input  logic [3:0]  fill_index,
  input  logic [16:0] sprite_base,
  input  logic [8:0]  sprite_w,
  input  logic [7:0]  sprite_h,
  input  logic [9:0]  dest_x,
  input  logic [8:0]  dest_y,
  input  logic        key_en,
  input  logic [3:0]  key_index,
  output logic        busy,
  output logic        done,
  output logic [16:0] src_addr,
  input  logic [3:0]  src_q,
  output logic [16:0] fb_addr,
  output logic [3:0]  fb_data,
  output logic        fb_we
);
  import fb_pkg::*;

  localparam int       TAIL    = SRC_LAT - 1;
  localparam logic [1:0] LAT_END = 2'(SRC_LAT - 1);

  blit_state_t state, state_nxt;

  logic       accept;
  logic       step;
  logic       last;
  logic       busy_nxt;
  logic       done_nxt;
  logic [1:0] lat_cnt;

  logic       fill_q;
  color_idx_t fill_idx_q;
  logic       key_en_q;
  color_idx_t key_q;

  fb_addr_t           gen_src;
  fb_addr_t           row_base;
  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic               in_bounds;
  fb_addr_t           pix_addr;

  logic [SRC_LAT-1:0] pv;
  logic [SRC_LAT-1:0] pin;
  fb_addr_t           pa [SRC_LAT];

  logic keyed;
  logic we_nxt;

  blit_addr_gen #(
    .STRIDE(FB_W)
  ) u_gen (
    .clk      (vga_clk),
    .rst_n    (reset_n),
    .load     (accept),
    .step     (step),
    .base     (sprite_base),
    .w        (sprite_w),
    .h        (sprite_h),
    .x0       (dest_x),
    .y0       (dest_y),
    .src_addr (gen_src),
    .dx       (dx),
    .dy       (dy),
    .row_base (row_base),
    .last     (last)
  );

  assign src_addr = gen_src;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (sprite_w == 9'd0 || sprite_h == 8'd0)
            state_nxt = FINISH;
          else
            state_nxt = ISSUE;
        end
      end
      ISSUE:  if (last) state_nxt = DRAIN;
      DRAIN:  if (lat_cnt == LAT_END) state_nxt = FINISH;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept   = (state == IDLE) && start;
    step     = (state == ISSUE);
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state == FINISH);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      lat_cnt <= '0;
    end else begin
      busy    <= busy_nxt;
      done    <= done_nxt;
      lat_cnt <= (state == DRAIN) ? lat_cnt + 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_q     <= 1'b0;
      fill_idx_q <= '0;
      key_en_q   <= 1'b0;
      key_q      <= '0;
    end else if (accept) begin
      fill_q     <= fill_mode;
      fill_idx_q <= fill_index;
      key_en_q   <= key_en;
      key_q      <= key_index;
    end
  end

  assign in_bounds = !dx[10] && ($unsigned(dx) < 11'(FB_W))
                  && !dy[10] && ($unsigned(dy) < 11'(FB_H));
  assign pix_addr  = row_base + {{6{dx[10]}}, dx};

  // Destination info rides alongside the ROM read so it
  // lines up with the matching src_q.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pv  <= '0;
      pin <= '0;
      for (int i = 0; i < SRC_LAT; i++) pa[i] <= '0;
    end else begin
      pv[0]  <= step;
      pin[0] <= in_bounds;
      pa[0]  <= pix_addr;
      for (int i = SRC_LAT - 1; i > 0; i--) begin
        pv[i]  <= pv[i-1];
        pin[i] <= pin[i-1];
        pa[i]  <= pa[i-1];
      end
    end
  end

  assign keyed  = !fill_q && key_en_q && (src_q == key_q);
  assign we_nxt = pv[TAIL] && pin[TAIL] && !keyed;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      fb_we <= we_nxt;
      if (we_nxt) begin
        fb_addr <= pa[TAIL];
        fb_data <= fill_q ? fill_idx_q : src_q;
      end
    end
  end

endmodule

// File: tb/tb_fb_sprite_blitter.sv
// Randomised bench for fb_sprite_blitter against a
// loop-based model of the blit rules.
module tb_fb_sprite_blitter;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        fill_mode = 1'b0;
  logic [3:0]  fill_index = '0;
  logic [16:0] sprite_base = '0;
  logic [8:0]  sprite_w = '0;
  logic [7:0]  sprite_h = '0;
  logic [9:0]  dest_x = '0;
  logic [8:0]  dest_y = '0;
  logic        key_en = 1'b0;
  logic [3:0]  key_index = '0;
  logic        busy;
  logic        done;
  logic [16:0] src_addr;
  logic [3:0]  src_q = '0;
  logic [16:0] fb_addr;
  logic [3:0]  fb_data;
  logic        fb_we;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [3:0] rom [0:131071];

  int exp_a[$];
  int exp_d[$];
  int got_a[$];
  int got_d[$];

  fb_sprite_blitter dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .start       (start),
    .fill_mode   (fill_mode),
    .fill_index  (fill_index),
    .sprite_base (sprite_base),
    .sprite_w    (sprite_w),
    .sprite_h    (sprite_h),
    .dest_x      (dest_x),
    .dest_y      (dest_y),
    .key_en      (key_en),
    .key_index   (key_index),
    .busy        (busy),
    .done        (done),
    .src_addr    (src_addr),
    .src_q       (src_q),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_we       (fb_we)
  );

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) cyc <= cyc + 1;

  // One-cycle-latency sprite ROM
  always @(posedge vga_clk) src_q <= rom[src_addr];

  task automatic build_model(input int w, input int h,
                             input int x, input int y,
                             input int base, input int fill,
                             input int fi, input int key,
                             input int ki);
    exp_a.delete();
    exp_d.delete();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int px, py, sa, pix;
        px  = x + c;
        py  = y + r;
        sa  = (base + r * w + c) % 131072;
        pix = int'(rom[sa]);
        if (px >= 0 && px < 320 && py >= 0 && py < 240 &&
            !(fill == 0 && key != 0 && pix == ki)) begin
          exp_a.push_back(px + py * 320);
          exp_d.push_back(fill != 0 ? fi : pix);
        end
      end
    end
  endtask

  task automatic run_blit(input string name,
                          input int w, input int h,
                          input int x, input int y,
                          input int base, input int fill,
                          input int fi, input int key,
                          input int ki, input bit poke);
    int n, acc, lat, exp_lat, bad_i;
    bit busy_bad, src_bad;
    logic [9:0] xv;
    logic [8:0] yv;
    n = w * h;
    xv = 10'(x);
    yv = 9'(y);
    build_model(w, h, x, y, base, fill, fi, key, ki);
    got_a.delete();
    got_d.delete();
    @(negedge vga_clk);
    sprite_w    = 9'(w);
    sprite_h    = 8'(h);
    dest_x      = xv;
    dest_y      = yv;
    sprite_base = 17'(base);
    fill_mode   = fill[0];
    fill_index  = 4'(fi);
    key_en      = key[0];
    key_index   = 4'(ki);
    start       = 1'b1;
    @(posedge vga_clk);
    #1;
    acc   = cyc;
    start = 1'b0;
    // Request inputs are latched; scramble them
    sprite_w    = 9'($urandom);
    sprite_h    = 8'($urandom);
    dest_x      = 10'($urandom);
    dest_y      = 9'($urandom);
    sprite_base = 17'($urandom);
    fill_mode   = 1'($urandom);
    fill_index  = 4'($urandom);
    key_en      = 1'($urandom);
    key_index   = 4'($urandom);
    lat = -1;
    busy_bad = 0;
    src_bad = 0;
    for (int k = 0; k < n + 100; k++) begin
      @(negedge vga_clk);
      if (fb_we) begin
        got_a.push_back(int'(fb_addr));
        got_d.push_back(int'(fb_data));
      end
      if (cyc - acc < n &&
          src_addr !== 17'((base + cyc - acc) % 131072))
        src_bad = 1;
      if (done) begin
        lat = cyc - acc;
        if (busy) busy_bad = 1;
        start = 1'b0;
        break;
      end
      if (!busy) busy_bad = 1;
      start = poke && busy && ((cyc - acc) % 5000 == 100);
    end
    start = 1'b0;
    exp_lat = (n == 0) ? 1 : n + 2;
    checks++;
    if (lat == -1) begin
      failures++;
      $display("FAIL %s timeout: done never seen, needed at %0d",
               name, exp_lat);
    end else if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d expected %0d",
               name, lat, exp_lat);
    end
    checks++;
    if (busy_bad) begin
      failures++;
      $display("FAIL %s busy window: got bad expected 1 then 0",
               name);
    end
    if (n > 0) begin
      checks++;
      if (src_bad) begin
        failures++;
        $display("FAIL %s src_addr: got wrong step expected %0d+k",
                 name, base);
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge vga_clk);
      if (k == 0) begin
        checks++;
        if (done !== 1'b0) begin
          failures++;
          $display("FAIL %s done width: got %b expected 0",
                   name, done);
        end
      end
      if (fb_we) begin
        got_a.push_back(int'(fb_addr));
        got_d.push_back(int'(fb_data));
      end
    end
    checks++;
    if (got_a.size() != exp_a.size()) begin
      failures++;
      $display("FAIL %s write count: got %0d expected %0d",
               name, got_a.size(), exp_a.size());
    end
    bad_i = -1;
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
      if (bad_i < 0 && (got_a[i] != exp_a[i] ||
                        got_d[i] != exp_d[i]))
        bad_i = i;
    checks++;
    if (bad_i >= 0) begin
      failures++;
      $display("FAIL %s write %0d: got a=%0d d=%0d expected a=%0d d=%0d",
               name, bad_i, got_a[bad_i], got_d[bad_i],
               exp_a[bad_i], exp_d[bad_i]);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge vga_clk);
    checks += 6;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset busy: got %b expected 0", busy);
    end
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL reset done: got %b expected 0", done);
    end
    if (fb_we !== 1'b0) begin
      failures++;
      $display("FAIL reset fb_we: got %b expected 0", fb_we);
    end
    if (src_addr !== 17'd0) begin
      failures++;
      $display("FAIL reset src_addr: got %0d expected 0", src_addr);
    end
    if (fb_addr !== 17'd0) begin
      failures++;
      $display("FAIL reset fb_addr: got %0d expected 0", fb_addr);
    end
    if (fb_data !== 4'd0) begin
      failures++;
      $display("FAIL reset fb_data: got %0d expected 0", fb_data);
    end
    reset_n = 1'b1;
    @(negedge vga_clk);
  endtask

  task automatic test_copy_basic();
    for (int i = 100; i < 108; i++) rom[i] = 4'(i - 99);
    run_blit("copy4x2", 4, 2, 10, 5, 100, 0, 0, 0, 0, 0);
  endtask

  task automatic test_key();
    for (int i = 100; i < 108; i++) rom[i] = 4'(i - 99);
    rom[102] = 4'd0;
    rom[105] = 4'd0;
    run_blit("key4x2", 4, 2, 10, 5, 100, 0, 0, 1, 0, 0);
  endtask

  task automatic test_clip();
    run_blit("clip", 4, 4, -2, 238, 500, 0, 0, 0, 0, 0);
    run_blit("clip_right", 6, 3, 317, -1, 900, 0, 0, 0, 0, 0);
  endtask

  task automatic test_empty();
    run_blit("w0", 0, 3, 5, 5, 0, 0, 0, 0, 0, 0);
    run_blit("h0", 5, 0, 5, 5, 0, 1, 3, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      int w, h, x, y, base, fill, key;
      w    = int'($urandom_range(0, 12));
      h    = int'($urandom_range(0, 10));
      x    = int'($urandom_range(0, 360)) - 20;
      y    = int'($urandom_range(0, 280)) - 20;
      base = int'($urandom_range(0, 131071));
      fill = ($urandom_range(0, 3) == 0) ? 1 : 0;
      key  = int'($urandom_range(0, 1));
      run_blit("random", w, h, x, y, base, fill,
               int'($urandom_range(0, 15)), key,
               int'($urandom_range(0, 15)), 0);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge vga_clk);
    sprite_w    = 9'd20;
    sprite_h    = 8'd10;
    dest_x      = 10'd3;
    dest_y      = 9'd4;
    sprite_base = 17'd0;
    fill_mode   = 1'b1;
    fill_index  = 4'd9;
    key_en      = 1'b0;
    start       = 1'b1;
    @(negedge vga_clk);
    start = 1'b0;
    repeat (40) @(negedge vga_clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks += 3;
    if (fb_we !== 1'b0) begin
      failures++;
      $display("FAIL midreset fb_we: got %b expected 0", fb_we);
    end
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset busy: got %b expected 0", busy);
    end
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL midreset done: got %b expected 0", done);
    end
    @(negedge vga_clk);
    reset_n = 1'b1;
    run_blit("after_reset", 7, 5, 50, 60, 1234, 0, 0, 1, 3, 0);
  endtask

  task automatic test_fill_full();
    run_blit("fill_full", 320, 240, 0, 0, 77, 1, 7, 1, 7, 1);
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) rom[i] = 4'($urandom);
    test_reset();
    test_copy_basic();
    test_key();
    test_clip();
    test_empty();
    test_random();
    test_reset_mid();
    test_fill_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not end, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
